// File: rtl/lif_pkg.sv
// Shared types, default parameters and the saturating helper for the LIF neuron.
package lif_pkg;

    typedef enum logic {
        LIF_RESET_ZERO = 1'b0,
        LIF_RESET_SUB  = 1'b1
    } lif_mode_e;

    localparam int LIF_DEF_WIDTH     = 8;
    localparam int LIF_DEF_DIV_WIDTH = 24;
    localparam int LIF_DEF_REFRAC    = 2;
    localparam int LIF_DEF_CNT_WIDTH = 8;

    // Widest membrane the saturate helper supports.
    localparam int LIF_MAX_W = 32;
    typedef logic [LIF_MAX_W:0] lif_wide_t;

    // Clamp an unsigned value to the largest number representable in `width` bits.
    function automatic logic [LIF_MAX_W-1:0] lif_saturate(input lif_wide_t sum, input int unsigned width);
        lif_wide_t lim;
        lim = (lif_wide_t'(1) << width) - lif_wide_t'(1);
        return (sum > lim) ? lim[LIF_MAX_W-1:0] : sum[LIF_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_step_timer.sv
// Integration-step prescaler: strobes step once every step_div+1 cycles.
module lif_step_timer
    import lif_pkg::*;
#(
    parameter int DIV_WIDTH = LIF_DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] step_div,
    output logic                 step
);

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;

    // >= lets a lowered step_div fire immediately instead of wrapping the counter.
    always_comb begin
        step      = (div_cnt_q >= step_div);
        div_cnt_d = step ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: leak, integrate, threshold, spike, refractory hold.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int WIDTH        = LIF_DEF_WIDTH,
    parameter int DIV_WIDTH    = LIF_DEF_DIV_WIDTH,
    parameter int REFRAC_STEPS = LIF_DEF_REFRAC,
    parameter int CNT_WIDTH    = LIF_DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     current,
    input  logic [WIDTH-1:0]     threshold,
    input  logic [2:0]           leak_shift,
    input  logic                 mode,
    input  logic [DIV_WIDTH-1:0] step_div,
    output logic [WIDTH-1:0]     membrane,
    output logic                 spike,
    output logic                 refractory,
    output logic [CNT_WIDTH-1:0] spike_count,
    output logic                 step
);

    localparam int RW = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);

    logic [WIDTH-1:0]     membrane_q, membrane_d;
    logic                 spike_q, spike_d;
    logic [CNT_WIDTH-1:0] spike_count_q, spike_count_d;
    logic [RW-1:0]        refrac_cnt_q, refrac_cnt_d;

    logic [WIDTH-1:0]     leak;
    logic [WIDTH:0]       sum_raw;
    logic [LIF_MAX_W-1:0] sat_full;
    logic [WIDTH-1:0]     sum_sat;
    logic                 in_refrac;
    logic                 fire;

    lif_step_timer #(.DIV_WIDTH(DIV_WIDTH)) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .step_div (step_div),
        .step     (step)
    );

    always_comb begin
        in_refrac = (refrac_cnt_q != '0);
        leak      = (leak_shift == 3'd0) ? '0 : (membrane_q >> leak_shift);
        // Leak never exceeds V, so the extra bit only ever carries overflow from the current.
        sum_raw   = {1'b0, membrane_q} - {1'b0, leak} + (in_refrac ? '0 : {1'b0, current});
        sat_full  = lif_saturate(lif_wide_t'(sum_raw), WIDTH);
        sum_sat   = sat_full[WIDTH-1:0];
        fire      = step && !in_refrac && (threshold != '0) && (sum_sat >= threshold);

        membrane_d    = membrane_q;
        spike_d       = 1'b0;
        spike_count_d = spike_count_q;
        refrac_cnt_d  = refrac_cnt_q;

        if (step) begin
            if (in_refrac) begin
                membrane_d   = sum_sat;
                refrac_cnt_d = refrac_cnt_q - RW'(1);
            end else if (fire) begin
                membrane_d    = (lif_mode_e'(mode) == LIF_RESET_SUB) ? (sum_sat - threshold) : '0;
                spike_d       = 1'b1;
                spike_count_d = spike_count_q + CNT_WIDTH'(1);
                refrac_cnt_d  = RW'(REFRAC_STEPS);
            end else begin
                membrane_d = sum_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            membrane_q    <= '0;
            spike_q       <= 1'b0;
            spike_count_q <= '0;
            refrac_cnt_q  <= '0;
        end else begin
            membrane_q    <= membrane_d;
            spike_q       <= spike_d;
            spike_count_q <= spike_count_d;
            refrac_cnt_q  <= refrac_cnt_d;
        end
    end

    assign membrane    = membrane_q;
    assign spike       = spike_q;
    assign refractory  = (refrac_cnt_q != '0);
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core: one instance with a 2-step refractory window, one with none.
module tb_lif_neuron_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [7:0]  cur_a = '0, thr_a = '0;
    logic [2:0]  ls_a = '0;
    logic        mode_a = 1'b0;
    logic [23:0] div_a = '0;
    logic [7:0]  mem_a, cnt_a;
    logic        spk_a, ref_a, stp_a;

    logic [7:0]  cur_b = '0, thr_b = '0;
    logic [7:0]  mem_b, cnt_b;
    logic        spk_b, ref_b, stp_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lif_neuron_core #(.WIDTH(8), .DIV_WIDTH(24), .REFRAC_STEPS(2), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .current(cur_a), .threshold(thr_a), .leak_shift(ls_a),
        .mode(mode_a), .step_div(div_a), .membrane(mem_a), .spike(spk_a),
        .refractory(ref_a), .spike_count(cnt_a), .step(stp_a)
    );

    lif_neuron_core #(.WIDTH(8), .DIV_WIDTH(24), .REFRAC_STEPS(0), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .current(cur_b), .threshold(thr_b), .leak_shift(3'd0),
        .mode(1'b0), .step_div(24'd0), .membrane(mem_b), .spike(spk_b),
        .refractory(ref_b), .spike_count(cnt_b), .step(stp_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        thr_a = 8'd100; cur_a = 8'd30;
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (mem_a !== 8'd0) $display("FAIL reset_membrane got %0d want 0", mem_a); else n_pass++;
        n_checks++; if (spk_a !== 1'b0) $display("FAIL reset_spike got %b want 0", spk_a); else n_pass++;
        n_checks++; if (ref_a !== 1'b0) $display("FAIL reset_refractory got %b want 0", ref_a); else n_pass++;
        n_checks++; if (cnt_a !== 8'd0) $display("FAIL reset_count got %0d want 0", cnt_a); else n_pass++;
        reset = 1'b0;
    endtask

    // mode 0, thr 100, cur 30: 30,60,90, fire at 120 -> 0, two refractory steps, then 30
    task automatic test_integrate_fire();
        int ev[7] = '{30, 60, 90, 0, 0, 0, 30};
        int es[7] = '{0, 0, 0, 1, 0, 0, 0};
        int er[7] = '{0, 0, 0, 1, 1, 0, 0};
        int ec[7] = '{0, 0, 0, 1, 1, 1, 1};
        div_a = '0; thr_a = 8'd100; cur_a = 8'd30; ls_a = '0; mode_a = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++; if (mem_a !== 8'(ev[i])) $display("FAIL if_membrane[%0d] got %0d want %0d", i, mem_a, ev[i]); else n_pass++;
            n_checks++; if (spk_a !== 1'(es[i])) $display("FAIL if_spike[%0d] got %b want %0d", i, spk_a, es[i]); else n_pass++;
            n_checks++; if (ref_a !== 1'(er[i])) $display("FAIL if_refractory[%0d] got %b want %0d", i, ref_a, er[i]); else n_pass++;
            n_checks++; if (cnt_a !== 8'(ec[i])) $display("FAIL if_count[%0d] got %0d want %0d", i, cnt_a, ec[i]); else n_pass++;
        end
    endtask

    task automatic test_subtract_mode();
        int ev[4] = '{30, 60, 90, 20};
        div_a = '0; thr_a = 8'd100; cur_a = 8'd30; ls_a = '0; mode_a = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (mem_a !== 8'(ev[i])) $display("FAIL sub_membrane[%0d] got %0d want %0d", i, mem_a, ev[i]); else n_pass++;
        end
        n_checks++; if (spk_a !== 1'b1) $display("FAIL sub_spike got %b want 1", spk_a); else n_pass++;
        mode_a = 1'b0;
    endtask

    task automatic test_saturation();
        int ev[4] = '{200, 255, 255, 255};
        div_a = '0; thr_a = 8'd0; cur_a = 8'd200; ls_a = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (mem_a !== 8'(ev[i])) $display("FAIL sat_membrane[%0d] got %0d want %0d", i, mem_a, ev[i]); else n_pass++;
            n_checks++; if (spk_a !== 1'b0) $display("FAIL sat_spike[%0d] got %b want 0", i, spk_a); else n_pass++;
        end
        n_checks++; if (cnt_a !== 8'd0) $display("FAIL sat_count got %0d want 0", cnt_a); else n_pass++;
    endtask

    task automatic test_leak();
        int ev[9] = '{64, 32, 16, 8, 4, 2, 1, 1, 1};
        div_a = '0; thr_a = 8'd0; cur_a = 8'd64; ls_a = 3'd1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick();
            cur_a = 8'd0;
            n_checks++; if (mem_a !== 8'(ev[i])) $display("FAIL leak_membrane[%0d] got %0d want %0d", i, mem_a, ev[i]); else n_pass++;
        end
        ls_a = 3'd0;
    endtask

    task automatic test_prescaler();
        int exp_v = 0;
        div_a = 24'd3; thr_a = 8'd0; cur_a = 8'd10; ls_a = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (stp_a !== ((i % 4) == 3)) $display("FAIL pre_step[%0d] got %b want %0d", i, stp_a, ((i % 4) == 3)); else n_pass++;
            n_checks++; if (mem_a !== 8'(exp_v)) $display("FAIL pre_membrane[%0d] got %0d want %0d", i, mem_a, exp_v); else n_pass++;
            if ((i % 4) == 3) exp_v += 10;
            tick();
        end
        // Lowering step_div below the running count must step at once.
        div_a = 24'd10;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (stp_a !== 1'b0) $display("FAIL pre_nostep got %b want 0", stp_a); else n_pass++;
        div_a = 24'd2;
        #1;
        n_checks++; if (stp_a !== 1'b1) $display("FAIL pre_lowered got %b want 1", stp_a); else n_pass++;
        div_a = '0;
    endtask

    task automatic test_reset_mid_refractory();
        div_a = '0; thr_a = 8'd100; cur_a = 8'd30; mode_a = 1'b0; ls_a = '0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (ref_a !== 1'b1) $display("FAIL mid_refractory_pre got %b want 1", ref_a); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (mem_a !== 8'd0) $display("FAIL mid_membrane got %0d want 0", mem_a); else n_pass++;
        n_checks++; if (spk_a !== 1'b0) $display("FAIL mid_spike got %b want 0", spk_a); else n_pass++;
        n_checks++; if (ref_a !== 1'b0) $display("FAIL mid_refractory got %b want 0", ref_a); else n_pass++;
        n_checks++; if (cnt_a !== 8'd0) $display("FAIL mid_count got %0d want 0", cnt_a); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        thr_b = 8'd1; cur_b = 8'd1;
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 1 || i == 2) begin
                n_checks++; if (spk_b !== 1'b1) $display("FAIL b2b_spike[%0d] got %b want 1", i, spk_b); else n_pass++;
                n_checks++; if (cnt_b !== 8'(i)) $display("FAIL b2b_count[%0d] got %0d want %0d", i, cnt_b, i); else n_pass++;
            end
            if (i == 255) begin
                n_checks++; if (cnt_b !== 8'd255) $display("FAIL wrap_count_255 got %0d want 255", cnt_b); else n_pass++;
            end
        end
        n_checks++; if (cnt_b !== 8'd0) $display("FAIL wrap_count_256 got %0d want 0", cnt_b); else n_pass++;
        n_checks++; if (ref_b !== 1'b0) $display("FAIL wrap_refractory got %b want 0", ref_b); else n_pass++;
        n_checks++; if (mem_b !== 8'd0) $display("FAIL wrap_membrane got %0d want 0", mem_b); else n_pass++;
        thr_b = 8'd0; cur_b = 8'd0;
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_subtract_mode();
        test_saturation();
        test_leak();
        test_prescaler();
        test_reset_mid_refractory();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
